// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter: two line buffers feed a sliding 3x3 window, and the
// saturated |Gx|+|Gy| plus a threshold flag are emitted for every interior pixel.
`timescale 1ns/1ps

module sobel_stream #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int THRESH     = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pix_in,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic [7:0] out_mag,
  output logic       out_edge,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eol
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [7:0]    THR      = 8'(THRESH);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  logic [7:0] lb0_mem [IMG_WIDTH];
  logic [7:0] lb1_mem [IMG_WIDTH];
  logic [7:0] lb0_rd, lb1_rd;

  logic [7:0] w_q [3][3];
  logic [7:0] w_d [3][3];

  logic s1_valid_q, s1_valid_d;
  logic s1_sof_q, s1_sof_d;
  logic s1_eol_q, s1_eol_d;

  logic [7:0] mag_q, mag_d;
  logic       edge_q, edge_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       eol_q, eol_d;

  logic        [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx, gy;
  logic        [10:0] gx_abs, gy_abs, mag_sum;
  logic        [7:0]  mag_sat;

  // A start-of-frame strobe relabels the current pixel as (0,0) on the same edge.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;
  assign lb0_rd  = lb0_mem[cur_col];
  assign lb1_rd  = lb1_mem[cur_col];

  // Stage 1: position counters, window shift and output qualifier.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    col_d      = col_q;
    row_d      = row_q;
    w_d        = w_q;
    s1_valid_d = 1'b0;
    s1_sof_d   = 1'b0;
    s1_eol_d   = 1'b0;
    if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      for (int r = 0; r < 3; r++) begin
        w_d[r][0] = w_q[r][1];
        w_d[r][1] = w_q[r][2];
      end
      w_d[0][2]  = lb1_rd;
      w_d[1][2]  = lb0_rd;
      w_d[2][2]  = pix_in;
      s1_valid_d = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      s1_sof_d   = (cur_row == ROW_TWO) && (cur_col == COL_TWO);
      s1_eol_d   = (cur_col == COL_LAST);
    end
  end

  // Stage 2: gradient arithmetic on the window registered in stage 1.
  always_comb begin
    gx_pos  = {2'b00, w_q[0][2]} + {1'b0, w_q[1][2], 1'b0} + {2'b00, w_q[2][2]};
    gx_neg  = {2'b00, w_q[0][0]} + {1'b0, w_q[1][0], 1'b0} + {2'b00, w_q[2][0]};
    gy_pos  = {2'b00, w_q[2][0]} + {1'b0, w_q[2][1], 1'b0} + {2'b00, w_q[2][2]};
    gy_neg  = {2'b00, w_q[0][0]} + {1'b0, w_q[0][1], 1'b0} + {2'b00, w_q[0][2]};
    gx      = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy      = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    gx_abs  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    gy_abs  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag_sum = gx_abs + gy_abs;
    mag_sat = (mag_sum > 11'd255) ? 8'hFF : mag_sum[7:0];

    mag_d   = s1_valid_q ? mag_sat : mag_q;
    edge_d  = s1_valid_q ? (mag_sat >= THR) : edge_q;
    valid_d = s1_valid_q;
    sof_d   = s1_valid_q & s1_sof_q;
    eol_d   = s1_valid_q & s1_eol_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      mag_q      <= '0;
      edge_q     <= 1'b0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_q[r][c] <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      w_q        <= w_d;
      s1_valid_q <= s1_valid_d;
      s1_sof_q   <= s1_sof_d;
      s1_eol_q   <= s1_eol_d;
      mag_q      <= mag_d;
      edge_q     <= edge_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
    end
  end

  // NOTE: line buffers have no reset so they map onto plain RAM; rows 0/1 refill them before use.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_mem[cur_col] <= lb0_rd;
      lb0_mem[cur_col] <= pix_in;
    end
  end

  assign out_mag   = mag_q;
  assign out_edge  = edge_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream: whole-frame vectors from a table plus hand-written
// latency, resync and reset sequences, scored against an image-level Sobel model.
`timescale 1ns/1ps

module tb_sobel_stream;

  localparam int W   = 160;
  localparam int H   = 120;
  localparam int THR = 128;
  localparam int FLAT = 0, STEP = 1, RAMP = 2;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       in_valid, in_sof;
  logic [7:0] out_mag;
  logic       out_edge, out_valid, out_sof, out_eol;

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(THR)) dut (
    .clk      (clk),
    .reset    (reset),
    .pix_in   (pix_in),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .out_mag  (out_mag),
    .out_edge (out_edge),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mag;
    logic       edge_f;
    logic       sof;
    logic       eol;
    int         cyc;
  } exp_t;

  typedef struct {
    int kind;
    bit sof;
    int exp_pulses;
    int exp_eol;
    int exp_sof;
    int exp_edges;
  } frame_vec_t;

  exp_t exp_q [64];
  int   wr_idx = 0;
  int   rd_idx = 0;
  int   cyc    = 0;
  int   n_pulse = 0, n_eol = 0, n_sof = 0, n_edge = 0, n_mism = 0;
  int   n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every pulse must match the next expected record, at the expected cycle.
  always @(negedge clk) begin
    if (reset) begin
      rd_idx <= wr_idx;
    end else if (out_valid) begin
      n_pulse <= n_pulse + 1;
      if (out_eol)  n_eol  <= n_eol + 1;
      if (out_sof)  n_sof  <= n_sof + 1;
      if (out_edge) n_edge <= n_edge + 1;
      if (rd_idx == wr_idx) begin
        n_mism <= n_mism + 1;
      end else begin
        if (out_mag !== exp_q[rd_idx % 64].mag || out_edge !== exp_q[rd_idx % 64].edge_f ||
            out_sof !== exp_q[rd_idx % 64].sof || out_eol !== exp_q[rd_idx % 64].eol ||
            cyc != exp_q[rd_idx % 64].cyc)
          n_mism <= n_mism + 1;
        rd_idx <= rd_idx + 1;
      end
    end else if (out_sof || out_eol) begin
      n_mism <= n_mism + 1;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int pix_of(input int kind, input int r, input int c);
    if (kind == FLAT) return 77;
    if (kind == STEP) return (c < 80) ? 0 : 255;
    return c;
  endfunction

  // Textbook Sobel on the image itself, centred on (r-1, c-1).
  function automatic int sobel_ref(input int kind, input int r, input int c);
    int k[3];
    int gx, gy, m;
    k[0] = 1; k[1] = 2; k[2] = 1;
    gx = 0;
    gy = 0;
    for (int d = 0; d < 3; d++) begin
      gx += k[d] * (pix_of(kind, r - 2 + d, c) - pix_of(kind, r - 2 + d, c - 2));
      gy += k[d] * (pix_of(kind, r, c - 2 + d) - pix_of(kind, r - 2, c - 2 + d));
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one pixel the bench places at (r,c) of the current frame.
  task automatic send_px(input int kind, input int r, input int c, input bit sof, input int gap);
    int m;
    pix_in   = 8'(pix_of(kind, r, c));
    in_valid = 1'b1;
    in_sof   = sof;
    if (r >= 2 && c >= 2) begin
      m = sobel_ref(kind, r, c);
      exp_q[wr_idx % 64].mag    = 8'(m);
      exp_q[wr_idx % 64].edge_f = (m >= THR);
      exp_q[wr_idx % 64].sof    = (r == 2 && c == 2);
      exp_q[wr_idx % 64].eol    = (c == W - 1);
      exp_q[wr_idx % 64].cyc    = cyc + 2;
      wr_idx++;
    end
    tick(1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic send_range(input int kind, input int r0, input int c0, input int r1, input int c1,
                            input int gap, input bit first_sof);
    int r, c;
    bit first;
    r = r0;
    c = c0;
    first = first_sof;
    forever begin
      send_px(kind, r, c, first, gap);
      first = 1'b0;
      if (r == r1 && c == c1) break;
      if (c == W - 1) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end else begin
        c++;
      end
    end
  endtask

  frame_vec_t vecs [2];
  int s_p, s_e, s_s, s_g, s_m, s_m0;

  initial begin
    vecs[0] = '{kind: FLAT, sof: 1'b1, exp_pulses: NOUT, exp_eol: H - 2, exp_sof: 1, exp_edges: 0};
    // Second frame follows without in_sof to exercise the frame wrap.
    vecs[1] = '{kind: STEP, sof: 1'b0, exp_pulses: NOUT, exp_eol: H - 2, exp_sof: 1, exp_edges: 2 * (H - 2)};

    reset    = 1'b1;
    pix_in   = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    tick(3);
    check("reset_outputs", int'({out_valid, out_mag, out_edge, out_sof, out_eol}), 0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 2; i++) begin
      s_p = n_pulse; s_e = n_eol; s_s = n_sof; s_g = n_edge; s_m = n_mism;
      send_range(vecs[i].kind, 0, 0, H - 1, W - 1, 0, vecs[i].sof);
      tick(4);
      check($sformatf("frame%0d_pulses", i), n_pulse - s_p, vecs[i].exp_pulses);
      check($sformatf("frame%0d_eol", i), n_eol - s_e, vecs[i].exp_eol);
      check($sformatf("frame%0d_sof", i), n_sof - s_s, vecs[i].exp_sof);
      check($sformatf("frame%0d_edges", i), n_edge - s_g, vecs[i].exp_edges);
      check($sformatf("frame%0d_mism", i), n_mism - s_m, 0);
      check($sformatf("frame%0d_pending", i), wr_idx - rd_idx, 0);
    end

    // Ramp with strobes 3 cycles apart; expected values carry the +2 latency.
    s_p = n_pulse; s_g = n_edge; s_m = n_mism;
    send_range(RAMP, 0, 0, 3, W - 1, 2, 1'b1);
    tick(4);
    check("ramp_pulses", n_pulse - s_p, 2 * (W - 2));
    check("ramp_edges", n_edge - s_g, 0);
    check("ramp_mism", n_mism - s_m, 0);

    // Single qualifying pixel: low at N+1, high at N+2, then held magnitude.
    send_px(RAMP, 4, 0, 1'b0, 0);
    send_px(RAMP, 4, 1, 1'b0, 0);
    send_px(RAMP, 4, 2, 1'b0, 0);
    check("lat_n1_valid", int'(out_valid), 0);
    tick(1);
    check("lat_n2_valid", int'(out_valid), 1);
    check("lat_n2_mag", int'(out_mag), 8);
    tick(1);
    check("lat_n3_valid", int'(out_valid), 0);
    check("lat_hold_mag", int'(out_mag), 8);

    // Resync at row 37 col 5: it becomes (0,0) and nothing comes out until the new (2,2).
    send_range(RAMP, 4, 3, 37, 4, 0, 1'b0);
    tick(3);
    s_p = n_pulse; s_m0 = n_mism;
    send_px(RAMP, 0, 0, 1'b1, 0);
    send_range(RAMP, 0, 1, 2, 1, 0, 1'b0);
    tick(3);
    check("resync_quiet", n_pulse - s_p, 0);
    s_p = n_pulse; s_s = n_sof;
    send_px(RAMP, 2, 2, 1'b0, 0);
    tick(3);
    check("resync_pulse", n_pulse - s_p, 1);
    check("resync_sof", n_sof - s_s, 1);
    check("resync_mism", n_mism - s_m0, 0);

    // Asynchronous reset with outputs in flight.
    send_px(RAMP, 2, 3, 1'b0, 0);
    send_px(RAMP, 2, 4, 1'b0, 0);
    send_px(RAMP, 2, 5, 1'b0, 0);
    check("pre_reset_valid", int'(out_valid), 1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'({out_valid, out_mag, out_edge, out_sof, out_eol}), 0);
    tick(3);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    s_p = n_pulse; s_e = n_eol; s_s = n_sof; s_g = n_edge; s_m = n_mism;
    send_range(FLAT, 0, 0, H - 1, W - 1, 0, 1'b0);
    tick(4);
    check("post_reset_pulses", n_pulse - s_p, NOUT);
    check("post_reset_eol", n_eol - s_e, H - 2);
    check("post_reset_sof", n_sof - s_s, 1);
    check("post_reset_edges", n_edge - s_g, 0);
    check("post_reset_mism", n_mism - s_m, 0);
    check("post_reset_pending", wr_idx - rd_idx, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
